// File: rtl/data_parity_merger_if.sv
// rtl/data_parity_merger_if.sv - stream bundle between the parity merger and its neighbours
interface data_parity_merger_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  axis_s_tvalid_odd;
   logic [DATA_WIDTH-1:0] axis_s_tdata_odd;
   logic                  axis_s_tlast_odd;
   logic                  axis_s_tready_odd;
   logic                  axis_s_tvalid_even;
   logic [DATA_WIDTH-1:0] axis_s_tdata_even;
   logic                  axis_s_tlast_even;
   logic                  axis_s_tready_even;
   logic                  axis_m_tvalid;
   logic [DATA_WIDTH-1:0] axis_m_tdata;
   logic                  axis_m_tlast;
   logic                  axis_m_tuser;
   logic                  axis_m_tready;

   // merger side: consumes both parity streams, produces the merged stream
   modport slave (
      input  axis_s_tvalid_odd, axis_s_tdata_odd, axis_s_tlast_odd,
      output axis_s_tready_odd,
      input  axis_s_tvalid_even, axis_s_tdata_even, axis_s_tlast_even,
      output axis_s_tready_even,
      output axis_m_tvalid, axis_m_tdata, axis_m_tlast, axis_m_tuser,
      input  axis_m_tready
   );

   // environment side: sources both parity streams, sinks the merged stream
   modport master (
      output axis_s_tvalid_odd, axis_s_tdata_odd, axis_s_tlast_odd,
      input  axis_s_tready_odd,
      output axis_s_tvalid_even, axis_s_tdata_even, axis_s_tlast_even,
      input  axis_s_tready_even,
      input  axis_m_tvalid, axis_m_tdata, axis_m_tlast, axis_m_tuser,
      output axis_m_tready
   );
endinterface

// File: rtl/data_parity_merger.sv
// rtl/data_parity_merger.sv - packet round-robin merge of odd/even parity streams with parity check
module data_parity_merger #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                 a_clk,
   input  logic                 axis_aresetn,
   data_parity_merger_if.slave  axis,
   output logic [CNT_WIDTH-1:0] parity_err_cnt
);
   typedef enum logic [1:0] {IDLE, ODD_PKT, EVEN_PKT} state_t;

   state_t                state_q;
   state_t                state_d;
   logic                  last_grant_odd_q;
   logic                  m_tvalid_q;
   logic [DATA_WIDTH-1:0] m_tdata_q;
   logic                  m_tlast_q;
   logic                  m_tuser_q;
   logic                  out_free;
   logic                  ready_odd;
   logic                  ready_even;
   logic                  accept_odd;
   logic                  accept_even;
   logic                  accept;
   logic [DATA_WIDTH-1:0] sel_tdata;
   logic                  sel_tlast;
   logic                  parity_bad;

   // the output register can take a beat when empty or draining this cycle
   assign out_free = !m_tvalid_q || axis.axis_m_tready;

   // arbitration and per-packet routing; IDLE grants nothing so every packet pays one bubble
   always_comb begin
      state_d    = state_q;
      ready_odd  = 1'b0;
      ready_even = 1'b0;
      case (state_q)
         IDLE: begin
            if (axis.axis_s_tvalid_even && (!axis.axis_s_tvalid_odd || last_grant_odd_q))
               state_d = EVEN_PKT;
            else if (axis.axis_s_tvalid_odd)
               state_d = ODD_PKT;
         end
         ODD_PKT: begin
            ready_odd = out_free;
            if (axis.axis_s_tvalid_odd && out_free && axis.axis_s_tlast_odd)
               state_d = IDLE;
         end
         EVEN_PKT: begin
            ready_even = out_free;
            if (axis.axis_s_tvalid_even && out_free && axis.axis_s_tlast_even)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // inputs stay not-ready for the whole reset, whatever state the register holds
   assign axis.axis_s_tready_odd  = ready_odd  && axis_aresetn;
   assign axis.axis_s_tready_even = ready_even && axis_aresetn;

   assign accept_odd  = axis.axis_s_tvalid_odd  && axis.axis_s_tready_odd;
   assign accept_even = axis.axis_s_tvalid_even && axis.axis_s_tready_even;
   assign accept      = accept_odd || accept_even;
   assign sel_tdata   = accept_odd ? axis.axis_s_tdata_odd : axis.axis_s_tdata_even;
   assign sel_tlast   = accept_odd ? axis.axis_s_tlast_odd : axis.axis_s_tlast_even;
   // odd port promises XOR = 1, even port XOR = 0
   assign parity_bad  = accept && ((^sel_tdata) != accept_odd);

   // state, grant memory, single output stage and saturating error counter
   always_ff @(posedge a_clk) begin
      if (!axis_aresetn) begin
         state_q          <= IDLE;
         last_grant_odd_q <= 1'b1;
         m_tvalid_q       <= 1'b0;
         m_tdata_q        <= '0;
         m_tlast_q        <= 1'b0;
         m_tuser_q        <= 1'b0;
         parity_err_cnt   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && state_d != IDLE)
            last_grant_odd_q <= (state_d == ODD_PKT);
         if (accept) begin
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= sel_tdata;
            m_tlast_q  <= sel_tlast;
            m_tuser_q  <= accept_odd;
         end else if (axis.axis_m_tready) begin
            m_tvalid_q <= 1'b0;
         end
         if (parity_bad && parity_err_cnt != {CNT_WIDTH{1'b1}})
            parity_err_cnt <= parity_err_cnt + CNT_WIDTH'(1);
      end
   end

   assign axis.axis_m_tvalid = m_tvalid_q;
   assign axis.axis_m_tdata  = m_tdata_q;
   assign axis.axis_m_tlast  = m_tlast_q;
   assign axis.axis_m_tuser  = m_tuser_q;
endmodule

// File: tb/tb_data_parity_merger.sv
// tb/tb_data_parity_merger.sv - directed table-driven bench for data_parity_merger
module tb_data_parity_merger;
   logic       clk = 1'b0;
   logic       resetn;
   logic [7:0] cnt8;
   logic [1:0] cnt2;
   int         n_chk  = 0;
   int         n_fail = 0;

   data_parity_merger_if #(.DATA_WIDTH(8)) bus ();
   data_parity_merger_if #(.DATA_WIDTH(8)) bus2 ();

   data_parity_merger #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
      .a_clk(clk), .axis_aresetn(resetn), .axis(bus.slave), .parity_err_cnt(cnt8));
   data_parity_merger #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut_sat (
      .a_clk(clk), .axis_aresetn(resetn), .axis(bus2.slave), .parity_err_cnt(cnt2));

   always #5 clk = ~clk;

   typedef struct {
      bit       rn;
      bit       vo;
      bit [7:0] od;
      bit       ol;
      bit       ve;
      bit [7:0] ed;
      bit       el;
      bit       mr;
      bit       ero;
      bit       ere;
      bit       emv;
      bit [7:0] emd;
      bit       eml;
      bit       emu;
      bit [7:0] ecnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit rn, bit vo, bit [7:0] od, bit ol, bit ve, bit [7:0] ed, bit el,
                               bit mr, bit ero, bit ere, bit emv, bit [7:0] emd, bit eml,
                               bit emu, bit [7:0] ecnt);
      vec_t v;
      v.rn = rn; v.vo = vo; v.od = od; v.ol = ol; v.ve = ve; v.ed = ed; v.el = el; v.mr = mr;
      v.ero = ero; v.ere = ere; v.emv = emv; v.emd = emd; v.eml = eml; v.emu = emu; v.ecnt = ecnt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   initial begin
      logic [7:0] bad [5];
      bad = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h07};

      // even packet 03,05,06 alone, full throughput after the IDLE cycle
      vecs.push_back(mk(1,0,8'h00,0,1,8'h03,0,1, 0,0, 0,8'h00,0,0,0));
      vecs.push_back(mk(1,0,8'h00,0,1,8'h03,0,1, 0,1, 1,8'h03,0,0,0));
      vecs.push_back(mk(1,0,8'h00,0,1,8'h05,0,1, 0,1, 1,8'h05,0,0,0));
      vecs.push_back(mk(1,0,8'h00,0,1,8'h06,1,1, 0,1, 1,8'h06,1,0,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,0,1, 0,0, 0,8'h00,0,0,0));
      // reset, then both ports continuously offering 2-beat packets
      vecs.push_back(mk(0,1,8'h01,0,1,8'h00,0,1, 0,0, 0,8'h00,0,0,0));
      vecs.push_back(mk(1,1,8'h01,0,1,8'h00,0,1, 0,0, 0,8'h00,0,0,0));
      vecs.push_back(mk(1,1,8'h01,0,1,8'h00,0,1, 0,1, 1,8'h00,0,0,0));
      vecs.push_back(mk(1,1,8'h01,0,1,8'h03,1,1, 0,1, 1,8'h03,1,0,0));
      vecs.push_back(mk(1,1,8'h01,0,1,8'h00,0,1, 0,0, 0,8'h00,0,0,0));
      vecs.push_back(mk(1,1,8'h01,0,1,8'h00,0,1, 1,0, 1,8'h01,0,1,0));
      vecs.push_back(mk(1,1,8'h02,1,1,8'h00,0,1, 1,0, 1,8'h02,1,1,0));
      vecs.push_back(mk(1,1,8'h01,0,1,8'h00,0,1, 0,0, 0,8'h00,0,0,0));
      vecs.push_back(mk(1,1,8'h01,0,1,8'h00,0,1, 0,1, 1,8'h00,0,0,0));
      vecs.push_back(mk(1,1,8'h01,0,1,8'h03,1,1, 0,1, 1,8'h03,1,0,0));
      vecs.push_back(mk(1,1,8'h01,0,0,8'h00,0,1, 0,0, 0,8'h00,0,0,0));
      vecs.push_back(mk(1,1,8'h01,0,0,8'h00,0,1, 1,0, 1,8'h01,0,1,0));
      vecs.push_back(mk(1,1,8'h02,1,0,8'h00,0,1, 1,0, 1,8'h02,1,1,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,0,1, 0,0, 0,8'h00,0,0,0));
      // odd 4-beat packet, downstream ready toggling 1,0,0,1,1,0,1
      vecs.push_back(mk(1,1,8'h01,0,0,8'h00,0,1, 0,0, 0,8'h00,0,0,0));
      vecs.push_back(mk(1,1,8'h01,0,0,8'h00,0,1, 1,0, 1,8'h01,0,1,0));
      vecs.push_back(mk(1,1,8'h02,0,0,8'h00,0,0, 0,0, 1,8'h01,0,1,0));
      vecs.push_back(mk(1,1,8'h02,0,0,8'h00,0,0, 0,0, 1,8'h01,0,1,0));
      vecs.push_back(mk(1,1,8'h02,0,0,8'h00,0,1, 1,0, 1,8'h02,0,1,0));
      vecs.push_back(mk(1,1,8'h04,0,0,8'h00,0,1, 1,0, 1,8'h04,0,1,0));
      vecs.push_back(mk(1,1,8'h07,1,0,8'h00,0,0, 0,0, 1,8'h04,0,1,0));
      vecs.push_back(mk(1,1,8'h07,1,0,8'h00,0,1, 1,0, 1,8'h07,1,1,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,0,0, 0,0, 1,8'h07,1,1,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,0,1, 0,0, 0,8'h00,0,0,0));
      // bad parity on both ports: forwarded and counted
      vecs.push_back(mk(1,1,8'h03,1,1,8'h01,1,1, 0,0, 0,8'h00,0,0,0));
      vecs.push_back(mk(1,1,8'h03,1,1,8'h01,1,1, 0,1, 1,8'h01,1,0,1));
      vecs.push_back(mk(1,1,8'h03,1,0,8'h00,0,1, 0,0, 0,8'h00,0,0,1));
      vecs.push_back(mk(1,1,8'h03,1,0,8'h00,0,1, 1,0, 1,8'h03,1,1,2));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,0,1, 0,0, 0,8'h00,0,0,2));
      // reset mid odd packet with a stalled output beat, then even wins first
      vecs.push_back(mk(1,1,8'h01,0,0,8'h00,0,0, 0,0, 0,8'h00,0,0,2));
      vecs.push_back(mk(1,1,8'h01,0,0,8'h00,0,0, 1,0, 1,8'h01,0,1,2));
      vecs.push_back(mk(1,1,8'h02,0,0,8'h00,0,0, 0,0, 1,8'h01,0,1,2));
      vecs.push_back(mk(0,1,8'h02,0,1,8'h05,1,0, 0,0, 0,8'h00,0,0,0));
      vecs.push_back(mk(1,1,8'h02,0,1,8'h05,1,1, 0,0, 0,8'h00,0,0,0));
      vecs.push_back(mk(1,1,8'h02,0,1,8'h05,1,1, 0,1, 1,8'h05,1,0,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,0,1, 0,0, 0,8'h00,0,0,0));
      // two single-beat packets offered together after reset
      vecs.push_back(mk(0,1,8'h07,1,1,8'h0C,1,1, 0,0, 0,8'h00,0,0,0));
      vecs.push_back(mk(1,1,8'h07,1,1,8'h0C,1,1, 0,0, 0,8'h00,0,0,0));
      vecs.push_back(mk(1,1,8'h07,1,1,8'h0C,1,1, 0,1, 1,8'h0C,1,0,0));
      vecs.push_back(mk(1,1,8'h07,1,0,8'h00,0,1, 0,0, 0,8'h00,0,0,0));
      vecs.push_back(mk(1,1,8'h07,1,0,8'h00,0,1, 1,0, 1,8'h07,1,1,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,0,1, 0,0, 0,8'h00,0,0,0));

      resetn = 1'b0;
      bus.axis_s_tvalid_odd  = 1'b0; bus.axis_s_tdata_odd  = 8'h00; bus.axis_s_tlast_odd  = 1'b0;
      bus.axis_s_tvalid_even = 1'b0; bus.axis_s_tdata_even = 8'h00; bus.axis_s_tlast_even = 1'b0;
      bus.axis_m_tready = 1'b1;
      bus2.axis_s_tvalid_odd  = 1'b0; bus2.axis_s_tdata_odd  = 8'h00; bus2.axis_s_tlast_odd  = 1'b0;
      bus2.axis_s_tvalid_even = 1'b0; bus2.axis_s_tdata_even = 8'h00; bus2.axis_s_tlast_even = 1'b0;
      bus2.axis_m_tready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      chk("reset m_tvalid", 32'(bus.axis_m_tvalid), 0);
      chk("reset m_tdata", 32'(bus.axis_m_tdata), 0);
      chk("reset m_tlast", 32'(bus.axis_m_tlast), 0);
      chk("reset m_tuser", 32'(bus.axis_m_tuser), 0);
      chk("reset tready_odd", 32'(bus.axis_s_tready_odd), 0);
      chk("reset tready_even", 32'(bus.axis_s_tready_even), 0);
      chk("reset cnt", 32'(cnt8), 0);
      resetn = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         resetn                 = vecs[i].rn;
         bus.axis_s_tvalid_odd  = vecs[i].vo;
         bus.axis_s_tdata_odd   = vecs[i].od;
         bus.axis_s_tlast_odd   = vecs[i].ol;
         bus.axis_s_tvalid_even = vecs[i].ve;
         bus.axis_s_tdata_even  = vecs[i].ed;
         bus.axis_s_tlast_even  = vecs[i].el;
         bus.axis_m_tready      = vecs[i].mr;
         #1;
         chk($sformatf("v%0d tready_odd", i), 32'(bus.axis_s_tready_odd), 32'(vecs[i].ero));
         chk($sformatf("v%0d tready_even", i), 32'(bus.axis_s_tready_even), 32'(vecs[i].ere));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d m_tvalid", i), 32'(bus.axis_m_tvalid), 32'(vecs[i].emv));
         if (vecs[i].emv) begin
            chk($sformatf("v%0d m_tdata", i), 32'(bus.axis_m_tdata), 32'(vecs[i].emd));
            chk($sformatf("v%0d m_tlast", i), 32'(bus.axis_m_tlast), 32'(vecs[i].eml));
            chk($sformatf("v%0d m_tuser", i), 32'(bus.axis_m_tuser), 32'(vecs[i].emu));
         end
         chk($sformatf("v%0d cnt", i), 32'(cnt8), 32'(vecs[i].ecnt));
      end

      // saturation on the 2-bit counter: five bad even bytes in one packet
      resetn = 1'b0;
      bus.axis_s_tvalid_odd = 1'b0; bus.axis_s_tvalid_even = 1'b0;
      @(posedge clk);
      #1;
      chk("sat reset cnt", 32'(cnt2), 0);
      resetn = 1'b1;
      bus2.axis_s_tvalid_even = 1'b1;
      bus2.axis_s_tdata_even  = bad[0];
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         bus2.axis_s_tdata_even = bad[i];
         bus2.axis_s_tlast_even = (i == 4);
         #1;
         chk($sformatf("sat%0d tready_even", i), 32'(bus2.axis_s_tready_even), 1);
         @(posedge clk);
         #1;
         chk($sformatf("sat%0d m_tdata", i), 32'(bus2.axis_m_tdata), 32'(bad[i]));
         chk($sformatf("sat%0d cnt", i), 32'(cnt2), (i < 3) ? i + 1 : 3);
      end
      bus2.axis_s_tvalid_even = 1'b0;
      bus2.axis_s_tlast_even  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("sat final cnt", 32'(cnt2), 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
